// File: rtl/apb_slave_mem.sv
// Parametrised APB slave memory: configurable width/depth/base, programmable wait states,
// PSLVERR on out-of-range/misaligned access, registered PRDATA. Byte strobes enabled by APB_SLV_PSTRB_EN.
module apb_slave_mem #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WAIT_CYC  = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);
  localparam int NB = DATA_W/8;
  localparam int LB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [IW-1:0]     idx_q;
  logic              err_q, wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] off, idx_full;
  logic              err_d, setup, access, done;

  // Underflow of off is harmless: the PADDR < BASE_ADDR term flags it.
  assign off      = PADDR - BASE_ADDR;
  assign idx_full = off >> LB;
  assign err_d    = (PADDR < BASE_ADDR) | (idx_full >= ADDR_W'(DEPTH)) |
                    ((PADDR & ADDR_W'(NB-1)) != '0);
  assign setup    = PSEL & ~PENABLE;
  assign access   = PSEL & PENABLE;

  assign PREADY   = (state == ACCESS) && (cnt == 4'd0);
  assign PSLVERR  = PREADY & err_q;
  assign done     = PREADY & access;

`ifdef APB_SLV_PSTRB_EN
  logic [NB-1:0] strb_q;
`else
  logic unused_pstrb;
  assign unused_pstrb = ^PSTRB;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (setup) begin
        state_nxt = ACCESS;
        cnt_nxt   = 4'(WAIT_CYC);
      end
      ACCESS: begin
        if (!PSEL)            state_nxt = IDLE;
        else if (setup)       cnt_nxt   = 4'(WAIT_CYC);  // fresh setup restarts the transfer
        else if (cnt == 4'd0) state_nxt = IDLE;
        else                  cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      PRDATA  <= '0;
`ifdef APB_SLV_PSTRB_EN
      strb_q  <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (setup) begin
        idx_q   <= idx_full[IW-1:0];
        err_q   <= err_d;
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
`ifdef APB_SLV_PSTRB_EN
        strb_q  <= PSTRB;
`endif
        if (!PWRITE) PRDATA <= err_d ? '0 : mem[idx_full[IW-1:0]];
      end
      if (done && wr_q && !err_q) begin
        for (int b = 0; b < NB; b++) begin
`ifdef APB_SLV_PSTRB_EN
          if (strb_q[b])
`endif
          mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end
endmodule
